// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: parametrised Fibonacci XNOR LFSR with a bounded-range random number port.
//
// Each request samples the low OUT_W bits of the LFSR, once per cycle, until a candidate
// falls inside [0, max_val]. After MAX_TRIES rejected candidates it returns 0 and flags
// the fallback path.
//
// Ports:
//   clk           in   clock
//   reset         in   synchronous, active-high reset
//   enable        in   advance the LFSR while idle
//   seed_load     in   load seed_in this cycle (an all-ones seed is replaced by SEED)
//   seed_in       in   [WIDTH]  seed value
//   req           in   request a random value (accepted only while busy is low)
//   max_val       in   [OUT_W]  inclusive upper bound, latched on accept
//   busy          out  a request is being sampled
//   rand_valid    out  one-cycle pulse, rand_out/rand_fallback valid
//   rand_out      out  [OUT_W]  result, held until the next rand_valid
//   rand_fallback out  result came from the fallback path
//   lfsr_state    out  [WIDTH]  current LFSR register
module lfsr_rand_gen #(
    parameter int unsigned      WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = 10'h240,
    parameter logic [WIDTH-1:0] SEED      = 10'h001,
    parameter int unsigned      OUT_W     = 4,
    parameter int unsigned      MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] max_val,
    output logic             busy,
    output logic             rand_valid,
    output logic [OUT_W-1:0] rand_out,
    output logic             rand_fallback,
    output logic [WIDTH-1:0] lfsr_state
);

    // One extra bit so the counter can never wrap before the fallback fires.
    localparam int unsigned      CNT_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSample
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] tries_q, tries_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             fb_q, fb_d;

    logic             feedback;
    logic [WIDTH-1:0] lfsr_adv;
    logic [OUT_W-1:0] cand;

    // XNOR feedback: the all-ones state is the lock-up state, never all-zeros.
    assign feedback = ~^(lfsr_q & TAPS);
    assign lfsr_adv = {lfsr_q[WIDTH-2:0], feedback};
    // Candidate comes from the registered state, before this cycle's advance.
    assign cand     = lfsr_q[OUT_W-1:0];

    // LFSR next state: seed load wins over advance.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (&seed_in) ? SEED : seed_in;
        end else if ((fsm_q == StIdle && enable) || fsm_q == StSample) begin
            lfsr_d = lfsr_adv;
        end
    end

    // Request FSM and result registers.
    always_comb begin
        fsm_d   = fsm_q;
        max_d   = max_q;
        tries_d = tries_q;
        valid_d = 1'b0;
        out_d   = out_q;
        fb_d    = fb_q;
        unique case (fsm_q)
            StIdle: begin
                if (req) begin
                    max_d   = max_val;
                    tries_d = '0;
                    fsm_d   = StSample;
                end
            end
            StSample: begin
                if (cand <= max_q) begin
                    out_d   = cand;
                    valid_d = 1'b1;
                    fb_d    = 1'b0;
                    fsm_d   = StIdle;
                end else if (tries_q == LAST_TRY) begin
                    out_d   = '0;
                    valid_d = 1'b1;
                    fb_d    = 1'b1;
                    fsm_d   = StIdle;
                end else begin
                    tries_d = tries_q + CNT_W'(1);
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= StIdle;
            lfsr_q  <= SEED;
            max_q   <= '0;
            tries_q <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            fb_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            max_q   <= max_d;
            tries_q <= tries_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            fb_q    <= fb_d;
        end
    end

    assign busy          = (fsm_q == StSample);
    assign rand_valid    = valid_q;
    assign rand_out      = out_q;
    assign rand_fallback = fb_q;
    assign lfsr_state    = lfsr_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Testbench for lfsr_rand_gen. A reference model predicts each request's result when it is
// accepted and pushes it to a scoreboard queue; a monitor pops and compares on rand_valid.
module tb_lfsr_rand_gen;

    localparam int unsigned WIDTH     = 10;
    localparam int unsigned OUT_W     = 4;
    localparam int unsigned MAX_TRIES = 4;
    localparam logic [9:0]  TAPS      = 10'h240;
    localparam logic [9:0]  SEED      = 10'h001;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             enable    = 1'b0;
    logic             seed_load = 1'b0;
    logic [WIDTH-1:0] seed_in   = '0;
    logic             req       = 1'b0;
    logic [OUT_W-1:0] max_val   = '0;
    logic             busy;
    logic             rand_valid;
    logic [OUT_W-1:0] rand_out;
    logic             rand_fallback;
    logic [WIDTH-1:0] lfsr_state;

    int checks = 0;
    int errors = 0;

    lfsr_rand_gen #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .SEED     (SEED),
        .OUT_W    (OUT_W),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .seed_load    (seed_load),
        .seed_in      (seed_in),
        .req          (req),
        .max_val      (max_val),
        .busy         (busy),
        .rand_valid   (rand_valid),
        .rand_out     (rand_out),
        .rand_fallback(rand_fallback),
        .lfsr_state   (lfsr_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [3:0] val;
        logic       fb;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] m_state = '0;
    int         m_busy  = 0;
    bit         m_ok    = 0;
    int         cyc     = 0;
    logic [9:0] m_ns;
    logic [3:0] m_pv;
    logic       m_pfb;
    int         m_pn;
    bit         m_acc;

    function automatic logic [9:0] ref_next(input logic [9:0] s);
        return {s[8:0], ~^(s & TAPS)};
    endfunction

    // Walk the candidate sequence from the state seen in the first sample cycle.
    function automatic void predict(input logic [9:0] s0, input logic [3:0] mx,
                                    output logic [3:0] v, output logic fb, output int n);
        logic [9:0] s;
        s  = s0;
        v  = '0;
        fb = 1'b1;
        n  = MAX_TRIES;
        for (int k = 0; k < MAX_TRIES; k++) begin
            if (s[3:0] <= mx) begin
                v  = s[3:0];
                fb = 1'b0;
                n  = k + 1;
                break;
            end
            s = ref_next(s);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_state = SEED;
                m_busy  = 0;
                exp_q.delete();
                m_ok    = 1;
            end else begin
                m_acc = req && (m_busy == 0);
                if (seed_load) m_ns = (&seed_in) ? SEED : seed_in;
                else if (m_busy != 0 || enable) m_ns = ref_next(m_state);
                else m_ns = m_state;
                if (m_busy != 0) m_busy--;
                if (m_acc) begin
                    predict(m_ns, max_val, m_pv, m_pfb, m_pn);
                    exp_q.push_back('{m_pv, m_pfb, cyc + m_pn});
                    m_busy = m_pn;
                end
                m_state = m_ns;
            end
        end
    end

    // Monitor: compares every cycle away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                checks++;
                if (lfsr_state !== m_state) begin
                    errors++;
                    $display("FAIL model_lfsr cyc=%0d: got %h, expected %h", cyc, lfsr_state, m_state);
                end
                checks++;
                if (busy !== (m_busy != 0)) begin
                    errors++;
                    $display("FAIL model_busy cyc=%0d: got %b, expected %b", cyc, busy, m_busy != 0);
                end
                if (rand_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_valid cyc=%0d: got rand_out %h, expected no valid",
                                 cyc, rand_out);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (rand_out !== mon_e.val || rand_fallback !== mon_e.fb || cyc != mon_e.cyc) begin
                            errors++;
                            $display("FAIL sb_result: got out=%h fb=%b cyc=%0d, expected out=%h fb=%b cyc=%0d",
                                     rand_out, rand_fallback, cyc, mon_e.val, mon_e.fb, mon_e.cyc);
                        end
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_missing_valid: got none at cyc %0d, expected out=%h at cyc %0d",
                             cyc, exp_q[0].val, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- tasks ----------------
    task automatic do_reset();
        reset     = 1'b1;
        req       = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        checks++;
        if (lfsr_state !== SEED) begin
            errors++;
            $display("FAIL reset_lfsr: got %h, expected %h", lfsr_state, SEED);
        end
        checks++;
        if ({busy, rand_valid, rand_out, rand_fallback} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b out=%h fb=%b, expected all 0",
                     busy, rand_valid, rand_out, rand_fallback);
        end
    endtask

    task automatic test_free_run();
        logic [9:0] seq [8];
        seq = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F, 10'h03F, 10'h07F, 10'h0FE};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (lfsr_state !== seq[i]) begin
                errors++;
                $display("FAIL free_run[%0d]: got %h, expected %h", i, lfsr_state, seq[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_first_request();
        do_reset();
        max_val = 4'd5;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || rand_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_req_busy: got busy=%b valid=%b, expected 1 0", busy, rand_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rand_valid !== 1'b1 || rand_out !== 4'd1 || rand_fallback !== 1'b0
            || lfsr_state !== 10'h003) begin
            errors++;
            $display("FAIL first_req_result: got busy=%b valid=%b out=%h fb=%b lfsr=%h, expected 0 1 1 0 003",
                     busy, rand_valid, rand_out, rand_fallback, lfsr_state);
        end
        // Request issued in the valid cycle is accepted.
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rand_valid !== 1'b1 || rand_out !== 4'd3 || lfsr_state !== 10'h007) begin
            errors++;
            $display("FAIL second_req_result: got valid=%b out=%h lfsr=%h, expected 1 3 007",
                     rand_valid, rand_out, lfsr_state);
        end
    endtask

    task automatic test_fallback();
        do_reset();
        seed_load = 1'b1;
        seed_in   = 10'h00F;
        @(negedge clk);
        seed_load = 1'b0;
        max_val   = 4'd2;
        req       = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || rand_valid !== 1'b0) begin
                errors++;
                $display("FAIL fallback_busy[%0d]: got busy=%b valid=%b, expected 1 0", i, busy, rand_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (rand_valid !== 1'b1 || rand_out !== 4'd0 || rand_fallback !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fallback_result: got valid=%b out=%h fb=%b busy=%b, expected 1 0 1 0",
                     rand_valid, rand_out, rand_fallback, busy);
        end
    endtask

    task automatic test_lockup();
        bit hit_lock;
        int early;
        hit_lock = 0;
        early    = 0;
        do_reset();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        seed_load = 1'b1;
        seed_in   = 10'h3FF;
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (lfsr_state !== 10'h001) begin
            errors++;
            $display("FAIL lockup_seed: got %h, expected 001", lfsr_state);
        end
        for (int i = 1; i <= 1023; i++) begin
            @(negedge clk);
            if (lfsr_state === 10'h3FF) hit_lock = 1;
            if (i < 1023 && lfsr_state === 10'h001 && early == 0) early = i;
            if (i == 1023) begin
                checks++;
                if (lfsr_state !== 10'h001) begin
                    errors++;
                    $display("FAIL lockup_period: got %h at cycle 1023, expected 001", lfsr_state);
                end
            end
        end
        checks++;
        if (hit_lock) begin
            errors++;
            $display("FAIL lockup_reached: got state 3ff, expected never");
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL lockup_short_period: got return at cycle %0d, expected 1023", early);
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvalid;
        do_reset();
        max_val = 4'hF;
        nvalid  = 0;
        req     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) req = 1'b0;
            if (rand_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 2) begin
            errors++;
            $display("FAIL b2b_valids: got %0d, expected 2", nvalid);
        end
        // State is now 007: max_val=0 rejects 7,15,15,15 then falls back.
        nvalid  = 0;
        max_val = 4'd0;
        req     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = (i == 1 || i == 3);
            if (rand_valid === 1'b1) nvalid++;
        end
        req = 1'b0;
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL collision_valids: got %0d, expected 1", nvalid);
        end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            enable    = 1'($urandom_range(0, 1));
            seed_load = ($urandom_range(0, 3) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
            max_val   = 4'($urandom);
            req       = 1'b1;
            @(negedge clk);
            req       = 1'b0;
            seed_load = 1'b0;
            k = 0;
            while (busy === 1'b1 && k < MAX_TRIES + 2) begin
                enable = 1'($urandom_range(0, 1));
                @(negedge clk);
                k++;
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL random_timeout[%0d]: got busy=%b, expected 0", n, busy);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nvalid;
        do_reset();
        seed_load = 1'b1;
        seed_in   = 10'h00F;
        @(negedge clk);
        seed_load = 1'b0;
        max_val   = 4'd0;
        req       = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || rand_valid !== 1'b0 || lfsr_state !== 10'h001) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b valid=%b lfsr=%h, expected 0 0 001",
                     busy, rand_valid, lfsr_state);
        end
        nvalid = 0;
        repeat (6) begin
            @(negedge clk);
            if (rand_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL reset_mid_valid: got %0d valids, expected 0", nvalid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_first_request();
        test_fallback();
        test_lockup();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
- Parametrised Fibonacci XNOR LFSR with a bounded-range random number request port.
- Successor to the fixed 10-bit LFSR. Adds configurable width and taps, runtime seed load, lock-up protection, and rejection sampling into the range [0, max_val].
- Feeds game logic such as lane and obstacle spawn selection. Consumers issue a request and receive one in-range value.

Parameters:
- WIDTH, 10: LFSR register width (>= 4).
- TAPS, 10'h240: tap mask; bit i set means state[i] is XNORed into the feedback.
- SEED, 10'h001: reset value and substitute seed. Must not be all-ones.
- OUT_W, 4: result width (<= WIDTH).
- MAX_TRIES, 8: number of rejections before fallback (>= 1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  free-run advance of the LFSR while idle.
- seed_load  in  1  load seed_in into the LFSR this cycle.
- seed_in  in  WIDTH  seed value.
- req  in  1  request a random value. Accepted only when busy=0.
- max_val  in  OUT_W  inclusive upper bound. Latched when req is accepted.
- busy  out  1  high while a request is being sampled.
- rand_valid  out  1  one-cycle pulse; rand_out is valid in that cycle.
- rand_out  out  OUT_W  result; holds its value until the next rand_valid.
- rand_fallback  out  1  qualifies rand_valid; high means the result came from the fallback path.
- lfsr_state  out  WIDTH  current LFSR register.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - lfsr_state=SEED, FSM=IDLE, busy=0, rand_valid=0, rand_out=0, rand_fallback=0, try counter=0.
  - Reset mid-request aborts the request; no rand_valid is produced.
- Advance:
  - next = {state[WIDTH-2:0], ~^(state & TAPS)}.
  - The LFSR advances when (FSM==IDLE && enable) or FSM==SAMPLE.
- Seed load:
  - seed_load has priority over advance in the same cycle.
  - If seed_in is all-ones (XNOR lock-up state), SEED is loaded instead.
  - seed_load during SAMPLE does not abort the request; sampling continues on the new state from the next cycle.
- FSM IDLE:
  - req=1 latches max_val, clears the try counter and moves to SAMPLE.
  - busy rises in the next cycle.
- FSM SAMPLE, each cycle:
  - cand = lfsr_state[OUT_W-1:0], taken from the registered value before this cycle's advance.
  - If cand <= latched max: rand_out<=cand, rand_valid<=1, rand_fallback<=0, go to IDLE.
  - Else, if try counter == MAX_TRIES-1: rand_out<=0, rand_valid<=1, rand_fallback<=1, go to IDLE.
  - Else: increment the try counter and stay in SAMPLE.
- Latency:
  - req is sampled at edge T; the first candidate is evaluated in cycle T+1.
  - rand_valid is high in cycle T+2 at minimum and T+1+MAX_TRIES at worst.
- Handshake details:
  - req while busy=1 is ignored; there is no queueing.
  - req in the cycle rand_valid is high is accepted, because the FSM is already in IDLE.
  - busy=1 exactly while FSM==SAMPLE.
- Edge cases:
  - max_val all-ones: the first candidate is always accepted.
  - max_val=0: only cand==0 is accepted.
  - The try counter width is clog2(MAX_TRIES)+1; there is no wrap before fallback.

Test Plan:
- Free run: reset, then enable=1, req=0 → lfsr_state = 0x001, 0x003, 0x007, 0x00F, 0x01F, 0x03F, 0x07F, 0x0FE on successive cycles.
- First request: reset, enable=0, req pulse with max_val=5 → busy=1 for 1 cycle; rand_valid at T+2 with rand_out=1, fallback=0; lfsr_state=0x003. A second request gives rand_out=3.
- Rejection with fallback: seed_load 0x00F, max_val=2, MAX_TRIES=4 → candidates 15, 15, 15, 15 rejected; rand_valid at T+5 with rand_out=0, rand_fallback=1.
- Lock-up guard: seed_load with seed_in=0x3FF → lfsr_state=0x001 next cycle. Then advancing with enable=1 never reaches 0x3FF over 1023 cycles, and the period is 1023 (state returns to 0x001 exactly at cycle 1023).
- Busy/collision: req held high for 4 cycles with max_val=15 → one rand_valid per accepted request, back-to-back accepts on the cycle of each valid; req pulses during busy produce no extra valid.
- Reset mid-request: seed 0x00F, max_val=0, reset asserted in the second SAMPLE cycle → no rand_valid, busy=0 and lfsr_state=0x001 the next cycle.
